// File: rtl/fir_mac_seq_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
package fir_mac_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fir_state_e;

    // Width of a select field addressing n items; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_mac_seq_coef_bank.sv
// NBANK x TAPS coefficient register file: one write port, one combinational read port.
module fir_mac_seq_coef_bank #(
    parameter int unsigned CW    = 16,
    parameter int unsigned TAPS  = 64,
    parameter int unsigned NBANK = 2,
    parameter int unsigned AW    = 6,
    parameter int unsigned BW    = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we_i,
    input  logic [BW-1:0] wbank_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [CW-1:0] wdata_i,
    input  logic [BW-1:0] rbank_i,
    input  logic [AW-1:0] raddr_i,
    output logic [CW-1:0] rdata_o
);

    logic [CW-1:0] mem_q [NBANK][TAPS];

    // Coefficient storage; out-of-range bank or tap writes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '{default: '0};
        end else if (we_i && (32'(wbank_i) < NBANK) && (32'(waddr_i) < TAPS)) begin
            mem_q[wbank_i][waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rbank_i][raddr_i];

endmodule

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR: one signed MAC per cycle over a TAPS-deep sample history,
// with run-time writable coefficient banks, valid/ready input and a result strobe.
module fir_mac_seq
    import fir_mac_seq_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned CW    = 16,
    parameter int unsigned TAPS  = 64,
    parameter int unsigned NBANK = 2,
    parameter int unsigned ACCW  = 40,
    parameter int unsigned SHIFT = 15,
    localparam int unsigned AW   = $clog2(TAPS),
    localparam int unsigned BW   = sel_width(NBANK)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x,
    input  logic [BW-1:0] bank_sel,
    input  logic          coef_we,
    input  logic [BW-1:0] coef_bank,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_wdata,
    output logic          out_valid,
    output logic [DW-1:0] y,
    output logic          out_sat
);

    fir_state_e                 state_q;
    logic        [AW-1:0]       k_q;
    logic        [AW-1:0]       wptr_q;
    logic        [BW-1:0]       bank_q;
    logic signed [ACCW-1:0]     acc_q;
    logic                       sat_q;
    logic signed [DW-1:0]       hist_q [TAPS];
    logic        [DW-1:0]       y_q;
    logic                       out_valid_q;
    logic                       out_sat_q;

    logic        [CW-1:0]       coef_rd;
    logic                       coef_we_eff;
    logic        [AW-1:0]       hidx;
    logic signed [DW+CW-1:0]    prod;
    logic signed [ACCW:0]       sum;
    logic signed [ACCW-1:0]     acc_d;
    logic                       acc_clamp;
    logic signed [ACCW-1:0]     shifted;
    logic        [DW-1:0]       y_d;
    logic                       y_clamp;

    // A result never mixes coefficients: writes to the bank in use are dropped while busy.
    assign coef_we_eff = coef_we && !((state_q != ST_IDLE) && (coef_bank == bank_q));
    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = out_valid_q;
    assign y           = y_q;
    assign out_sat     = out_sat_q;

    fir_mac_seq_coef_bank #(
        .CW    (CW),
        .TAPS  (TAPS),
        .NBANK (NBANK),
        .AW    (AW),
        .BW    (BW)
    ) u_coef (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (coef_we_eff),
        .wbank_i (coef_bank),
        .waddr_i (coef_addr),
        .wdata_i (coef_wdata),
        .rbank_i (bank_q),
        .raddr_i (k_q),
        .rdata_o (coef_rd)
    );

    // History index (wptr - k) mod TAPS; also correct when TAPS is not a power of two.
    always_comb begin
        hidx = wptr_q - k_q;
        if (k_q > wptr_q) begin
            hidx = wptr_q + AW'(TAPS) - k_q;
        end
    end

    // Saturating multiply-accumulate and output scaling/clamping.
    always_comb begin
        prod      = (DW+CW)'($signed(coef_rd)) * (DW+CW)'(hist_q[hidx]);
        sum       = (ACCW+1)'(acc_q) + (ACCW+1)'(prod);
        acc_clamp = (sum[ACCW] != sum[ACCW-1]);
        acc_d     = sum[ACCW-1:0];
        if (acc_clamp) begin
            acc_d = sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
        end
        shifted = acc_q >>> SHIFT;
        y_clamp = !((&shifted[ACCW-1:DW-1]) || !(|shifted[ACCW-1:DW-1]));
        y_d     = shifted[DW-1:0];
        if (y_clamp) begin
            y_d = shifted[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

    // Control FSM with datapath registers: accept, TAPS MAC cycles, publish result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            wptr_q      <= '0;
            bank_q      <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            hist_q      <= '{default: '0};
            y_q         <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else if (clear) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            wptr_q      <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            hist_q      <= '{default: '0};
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        hist_q[wptr_q] <= x;
                        bank_q         <= (32'(bank_sel) < NBANK) ? bank_sel : '0;
                        acc_q          <= '0;
                        sat_q          <= 1'b0;
                        k_q            <= '0;
                        state_q        <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    sat_q <= sat_q | acc_clamp;
                    k_q   <= k_q + 1'b1;
                    if (k_q == AW'(TAPS - 1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    y_q         <= y_d;
                    out_valid_q <= 1'b1;
                    out_sat_q   <= sat_q | y_clamp;
                    wptr_q      <= (wptr_q == AW'(TAPS - 1)) ? '0 : wptr_q + 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: three instances (TAPS=4/SHIFT=0, TAPS=4/SHIFT=15, defaults),
// table-driven vectors plus hand sequences, scoreboard queue checked on out_valid.
module tb_fir_mac_seq;

    typedef struct {
        int          dut;
        logic [15:0] y;
        logic        sat;
    } exp_t;

    typedef struct {
        int          dut;
        bit          clr;
        logic [15:0] x;
        logic        bank;
        logic [15:0] y;
        logic        sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid_r  [3];
    logic        bank_sel_r  [3];
    logic        coef_we_r   [3];
    logic        coef_bank_r [3];
    logic [15:0] x_r         [3];
    logic [15:0] coef_wdata_r[3];
    logic [5:0]  coef_addr_r [3];
    logic        in_ready_w  [3];
    logic        out_valid_w [3];
    logic        out_sat_w   [3];
    logic [15:0] y_w         [3];

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sbq[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_mac_seq #(.TAPS(4), .SHIFT(0)) u_a (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid_r[0]), .in_ready(in_ready_w[0]), .x(x_r[0]), .bank_sel(bank_sel_r[0]),
        .coef_we(coef_we_r[0]), .coef_bank(coef_bank_r[0]), .coef_addr(coef_addr_r[0][1:0]),
        .coef_wdata(coef_wdata_r[0]), .out_valid(out_valid_w[0]), .y(y_w[0]), .out_sat(out_sat_w[0])
    );

    fir_mac_seq #(.TAPS(4), .SHIFT(15)) u_b (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid_r[1]), .in_ready(in_ready_w[1]), .x(x_r[1]), .bank_sel(bank_sel_r[1]),
        .coef_we(coef_we_r[1]), .coef_bank(coef_bank_r[1]), .coef_addr(coef_addr_r[1][1:0]),
        .coef_wdata(coef_wdata_r[1]), .out_valid(out_valid_w[1]), .y(y_w[1]), .out_sat(out_sat_w[1])
    );

    fir_mac_seq u_c (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid_r[2]), .in_ready(in_ready_w[2]), .x(x_r[2]), .bank_sel(bank_sel_r[2]),
        .coef_we(coef_we_r[2]), .coef_bank(coef_bank_r[2]), .coef_addr(coef_addr_r[2]),
        .coef_wdata(coef_wdata_r[2]), .out_valid(out_valid_w[2]), .y(y_w[2]), .out_sat(out_sat_w[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input int d, input logic [15:0] yv, input logic s);
        exp_t e;
        e.dut = d;
        e.y   = yv;
        e.sat = s;
        sbq.push_back(e);
    endtask

    // Scoreboard: every result strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (out_valid_w[d] === 1'b1) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out dut%0d: got y=0x%0h, required no output", d, y_w[d]);
                end else begin
                    mon_e = sbq.pop_front();
                    check("out_dut", 32'(d), 32'(mon_e.dut));
                    check("out_y", 32'(y_w[d]), 32'(mon_e.y));
                    check("out_sat", 32'(out_sat_w[d]), 32'(mon_e.sat));
                end
            end
        end
    end

    // All tasks below are entered and left at a falling clock edge.
    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic write_coef(input int d, input logic b, input logic [5:0] a, input logic [15:0] v);
        coef_we_r[d]    = 1'b1;
        coef_bank_r[d]  = b;
        coef_addr_r[d]  = a;
        coef_wdata_r[d] = v;
        @(negedge clk);
        coef_we_r[d] = 1'b0;
    endtask

    task automatic send_w(input int d, input logic [15:0] xv, input logic b, input logic we,
                          input logic [15:0] wd, output int acc_cyc);
        int n;
        n = 0;
        while (!in_ready_w[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout dut%0d: got in_ready=0 for 200 cycles, required 1", d);
        end
        in_valid_r[d]   = 1'b1;
        x_r[d]          = xv;
        bank_sel_r[d]   = b;
        coef_we_r[d]    = we;
        coef_bank_r[d]  = 1'b0;
        coef_addr_r[d]  = '0;
        coef_wdata_r[d] = wd;
        @(negedge clk);
        acc_cyc       = cyc;
        in_valid_r[d] = 1'b0;
        coef_we_r[d]  = 1'b0;
    endtask

    task automatic send(input int d, input logic [15:0] xv, input logic b, output int acc_cyc);
        send_w(d, xv, b, 1'b0, 16'h0, acc_cyc);
    endtask

    task automatic wait_out(input int d, output int seen_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid_w[d] && n < 300);
        if (!out_valid_w[d]) begin
            tests++;
            fails++;
            $display("FAIL out_timeout dut%0d: got no out_valid in 300 cycles, required one", d);
        end
        seen_cyc = cyc;
    endtask

    task automatic count_ov(input int d, input int ncyc, output int cnt);
        cnt = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (out_valid_w[d]) cnt++;
        end
    endtask

    task automatic load_impulse_coefs();
        for (int unsigned k = 0; k < 4; k++) write_coef(0, 1'b0, 6'(k), 16'(k + 1));
        write_coef(0, 1'b1, 6'd0, 16'hFFFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no summary by 200us, required completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        int   ac, oc, cnt, n, last, guard, taps;

        for (int d = 0; d < 3; d++) begin
            in_valid_r[d]   = 1'b0;
            bank_sel_r[d]   = 1'b0;
            coef_we_r[d]    = 1'b0;
            coef_bank_r[d]  = 1'b0;
            x_r[d]          = '0;
            coef_wdata_r[d] = '0;
            coef_addr_r[d]  = '0;
        end

        // dut, clear-first, x, bank, expected y, expected sat
        vecs.push_back('{0, 1'b0, 16'h0001, 1'b0, 16'h0001, 1'b0});
        vecs.push_back('{0, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b0});
        vecs.push_back('{0, 1'b0, 16'h0000, 1'b0, 16'h0003, 1'b0});
        vecs.push_back('{0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b0});
        vecs.push_back('{0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{0, 1'b0, 16'h0005, 1'b1, 16'hFFFB, 1'b0});
        vecs.push_back('{0, 1'b0, 16'h0000, 1'b0, 16'h000A, 1'b0});
        vecs.push_back('{1, 1'b0, 16'h7FFF, 1'b0, 16'h7FFE, 1'b0});
        vecs.push_back('{1, 1'b0, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1});
        vecs.push_back('{1, 1'b1, 16'h8000, 1'b0, 16'h8001, 1'b0});
        vecs.push_back('{1, 1'b0, 16'h8000, 1'b0, 16'h8000, 1'b1});
        vecs.push_back('{2, 1'b0, 16'h7FFF, 1'b0, 16'h3FFF, 1'b0});
        vecs.push_back('{2, 1'b0, 16'h8000, 1'b0, 16'hC000, 1'b0});

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_y", 32'(y_w[d]), 32'h0);
            check("rst_out_valid", 32'(out_valid_w[d]), 32'h0);
            check("rst_out_sat", 32'(out_sat_w[d]), 32'h0);
            check("rst_in_ready", 32'(in_ready_w[d]), 32'h1);
        end
        reset_n = 1'b1;
        @(negedge clk);

        load_impulse_coefs();
        for (int unsigned k = 0; k < 4; k++) write_coef(1, 1'b0, 6'(k), 16'h7FFF);
        write_coef(2, 1'b0, 6'd0, 16'h4000);

        // Table-driven single-sample transactions with latency check.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].clr) pulse_clear();
            send(vecs[i].dut, vecs[i].x, vecs[i].bank, ac);
            expect_out(vecs[i].dut, vecs[i].y, vecs[i].sat);
            wait_out(vecs[i].dut, oc);
            taps = (vecs[i].dut == 2) ? 64 : 4;
            check("latency", 32'(oc - ac), 32'(taps + 1));
        end

        // Writes during RUN: latched bank dropped, other bank takes effect next sample.
        pulse_clear();
        send(0, 16'd5, 1'b1, ac);
        expect_out(0, 16'hFFFB, 1'b0);
        write_coef(0, 1'b1, 6'd0, 16'd7);
        write_coef(0, 1'b0, 6'd0, 16'd10);
        wait_out(0, oc);
        send(0, 16'd2, 1'b1, ac);
        expect_out(0, 16'hFFFE, 1'b0);
        wait_out(0, oc);
        send(0, 16'd0, 1'b0, ac);
        expect_out(0, 16'd19, 1'b0);
        wait_out(0, oc);
        send(0, 16'd1, 1'b0, ac);
        expect_out(0, 16'd36, 1'b0);
        wait_out(0, oc);

        // Coefficient write in the accept cycle is seen by that sample.
        pulse_clear();
        send_w(0, 16'd1, 1'b0, 1'b1, 16'd1, ac);
        expect_out(0, 16'd1, 1'b0);
        wait_out(0, oc);
        for (int unsigned k = 2; k <= 4; k++) begin
            send(0, 16'd0, 1'b0, ac);
            expect_out(0, 16'(k), 1'b0);
            wait_out(0, oc);
        end

        // Handshake: in_valid held high, one accept every TAPS+2 cycles.
        pulse_clear();
        in_valid_r[0] = 1'b1;
        x_r[0]        = 16'd1;
        bank_sel_r[0] = 1'b0;
        n = 0; last = 0; guard = 0;
        while (n < 3 && guard < 100) begin
            if (in_ready_w[0]) begin
                expect_out(0, (n == 0) ? 16'd1 : (n == 1) ? 16'd3 : 16'd6, 1'b0);
                if (n > 0) check("accept_period", 32'(cyc - last), 32'd6);
                last = cyc;
                n++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid_r[0] = 1'b0;
        check("accept_count", 32'(n), 32'd3);
        wait_out(0, oc);

        // Async reset mid-RUN: immediate reset state, result discarded, coefficients zeroed.
        send(0, 16'd7, 1'b0, ac);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrun_rst_y", 32'(y_w[0]), 32'h0);
        check("midrun_rst_in_ready", 32'(in_ready_w[0]), 32'h1);
        check("midrun_rst_out_valid", 32'(out_valid_w[0]), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        count_ov(0, 8, cnt);
        check("midrun_rst_no_out", 32'(cnt), 32'h0);
        send(1, 16'h7FFF, 1'b0, ac);
        expect_out(1, 16'h0000, 1'b0);
        wait_out(1, oc);

        load_impulse_coefs();
        for (int unsigned k = 1; k <= 4; k++) begin
            send(0, (k == 1) ? 16'd1 : 16'd0, 1'b0, ac);
            expect_out(0, 16'(k), 1'b0);
            wait_out(0, oc);
        end

        // Clear mid-RUN: no result, y held, history restarts from zero.
        send(0, 16'd9, 1'b0, ac);
        @(negedge clk);
        pulse_clear();
        count_ov(0, 10, cnt);
        check("midrun_clr_no_out", 32'(cnt), 32'h0);
        check("midrun_clr_y_held", 32'(y_w[0]), 32'd4);
        for (int unsigned k = 1; k <= 4; k++) begin
            send(0, (k == 1) ? 16'd1 : 16'd0, 1'b0, ac);
            expect_out(0, 16'(k), 1'b0);
            wait_out(0, oc);
        end

        repeat (2) @(negedge clk);
        check("pending_results", 32'(sbq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
